// File: rtl/alsu_pipe.sv
// Handshaked arithmetic/logic/shift unit: single-cycle ops finish in one EXEC
// cycle, MUL runs a WIDTH-cycle shift-add; errors are sticky and blink the LEDs.
module alsu_pipe #(
   parameter int WIDTH          = 3,
   parameter     INPUT_PRIORITY = "A",
   parameter     FULL_ADDER     = "ON",
   parameter int LED_W          = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 cin,
   input  logic                 serial_in,
   input  logic                 direction,
   input  logic                 red_op_A,
   input  logic                 red_op_B,
   input  logic                 bypass_A,
   input  logic                 bypass_B,
   input  logic [2:0]           opcode,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   output logic                 err,
   output logic [LED_W-1:0]     leds
);

   localparam int OW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam bit PRIO_A   = (INPUT_PRIORITY == "A");
   localparam bit CIN_USED = (FULL_ADDER == "ON");

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_XOR = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SHL = 3'b100;
   localparam logic [2:0] OP_ROT = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

   state_t state_q, state_d;

   // captured request fields
   logic [WIDTH-1:0] a_q, b_q;
   logic             cin_q, sin_q, dir_q;
   logic             red_a_q, red_b_q, byp_a_q, byp_b_q;
   logic [2:0]       op_q;

   logic [OW-1:0]    out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             err_q, err_d;
   logic [LED_W-1:0] leds_q, leds_d;

   logic [OW-1:0]    acc_q, acc_d, acc_sum;
   logic [OW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept, go_mul, mul_last;
   logic [OW-1:0]    exec_res;
   logic             exec_inv;
   logic             red_bit;

   assign accept   = in_valid && in_ready;
   assign go_mul   = (opcode == OP_MUL) && !bypass_A && !bypass_B && !red_op_A && !red_op_B;
   assign mul_last = (cnt_q == CW'(WIDTH - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = go_mul ? S_MUL : S_EXEC;
         S_EXEC: state_d = S_IDLE;
         S_MUL:  if (mul_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = (state_q == S_IDLE);
   end

   // Single-cycle result, resolved by bypass > invalid > opcode priority.
   always_comb begin
      exec_res = '0;
      exec_inv = 1'b0;
      red_bit  = 1'b0;
      if (byp_a_q && byp_b_q) begin
         exec_res = PRIO_A ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{1'b0}}, b_q};
      end else if (byp_a_q) begin
         exec_res = {{WIDTH{1'b0}}, a_q};
      end else if (byp_b_q) begin
         exec_res = {{WIDTH{1'b0}}, b_q};
      end else if (op_q[2:1] == 2'b11 ||
                   ((red_a_q || red_b_q) && op_q[2:1] != 2'b00)) begin
         exec_inv = 1'b1;
      end else begin
         case (op_q)
            OP_AND: begin
               if (red_a_q && red_b_q) red_bit = PRIO_A ? &a_q : &b_q;
               else if (red_a_q)       red_bit = &a_q;
               else                    red_bit = &b_q;
               exec_res = (red_a_q || red_b_q) ? {{(OW-1){1'b0}}, red_bit}
                                               : {{WIDTH{1'b0}}, a_q & b_q};
            end
            OP_XOR: begin
               if (red_a_q && red_b_q) red_bit = PRIO_A ? ^a_q : ^b_q;
               else if (red_a_q)       red_bit = ^a_q;
               else                    red_bit = ^b_q;
               exec_res = (red_a_q || red_b_q) ? {{(OW-1){1'b0}}, red_bit}
                                               : {{WIDTH{1'b0}}, a_q ^ b_q};
            end
            OP_ADD: exec_res = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q}
                             + {{(OW-1){1'b0}}, (cin_q & CIN_USED)};
            OP_SHL: exec_res = dir_q ? {out_q[OW-2:0], sin_q}
                                     : {sin_q, out_q[OW-1:1]};
            OP_ROT: exec_res = dir_q ? {out_q[OW-2:0], out_q[OW-1]}
                                     : {out_q[0], out_q[OW-1:1]};
            default: exec_res = '0;
         endcase
      end
   end

   // Datapath next-state: result register, error/LED bank, shift-add multiplier.
   always_comb begin
      out_d       = out_q;
      out_valid_d = 1'b0;
      err_d       = err_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      acc_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
      case (state_q)
         S_EXEC: begin
            out_d       = exec_res;
            out_valid_d = 1'b1;
            err_d       = exec_inv;
         end
         S_MUL: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (mul_last) begin
               out_d       = acc_sum;
               out_valid_d = 1'b1;
               err_d       = 1'b0;
            end
         end
         default: ;
      endcase
      if (accept) begin
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, A};
         mplier_d = B;
         cnt_d    = '0;
      end
      // first blink value is all ones on the edge where err rises
      leds_d = err_d ? ~leds_q : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         sin_q    <= 1'b0;
         dir_q    <= 1'b0;
         red_a_q  <= 1'b0;
         red_b_q  <= 1'b0;
         byp_a_q  <= 1'b0;
         byp_b_q  <= 1'b0;
         op_q     <= '0;
      end else if (accept) begin
         a_q      <= A;
         b_q      <= B;
         cin_q    <= cin;
         sin_q    <= serial_in;
         dir_q    <= direction;
         red_a_q  <= red_op_A;
         red_b_q  <= red_op_B;
         byp_a_q  <= bypass_A;
         byp_b_q  <= bypass_B;
         op_q     <= opcode;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         leds_q      <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         leds_q      <= leds_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;
   assign leds      = leds_q;

endmodule

// File: tb/tb_alsu_pipe.sv
// Directed bench for alsu_pipe (WIDTH=3): handshake timing, each op class,
// sticky error with LED blink, bypass priority, shift/rotate and reset abort.
module tb_alsu_pipe;

   localparam int W = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   A, B;
   logic           cin, serial_in, direction;
   logic           red_op_A, red_op_B, bypass_A, bypass_B;
   logic [2:0]     opcode;
   logic [2*W-1:0] out;
   logic           out_valid;
   logic           err;
   logic [15:0]    leds;

   int n_total  = 0;
   int n_passed = 0;

   alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .cin(cin), .serial_in(serial_in), .direction(direction),
      .red_op_A(red_op_A), .red_op_B(red_op_B),
      .bypass_A(bypass_A), .bypass_B(bypass_B), .opcode(opcode),
      .out(out), .out_valid(out_valid), .err(err), .leds(leds)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_passed++;
         $display("check %-14s observed %0h expected %0h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs;
      in_valid = 0; A = 0; B = 0; cin = 0; serial_in = 0; direction = 0;
      red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0; opcode = 3'b000;
   endtask

   // drive one request and step through the accept edge
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      opcode = op; A = a; B = b; in_valid = 1;
      tick();
      in_valid = 0;
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      tick(); tick();
      rst = 0;
      tick();
      check("rst_out",       32'(out),       32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_err",       32'(err),       32'd0);
      check("rst_leds",      32'(leds),      32'd0);

      // ADD 5+3+1 = 9, one-cycle latency
      cin = 1;
      issue(3'b010, 3'd5, 3'd3);
      check("add_busy",      32'(in_ready),  32'd0);
      check("add_nv_k",      32'(out_valid), 32'd0);
      tick();
      check("add_out",       32'(out),       32'd9);
      check("add_valid",     32'(out_valid), 32'd1);
      check("add_ready",     32'(in_ready),  32'd1);
      tick();
      check("add_pulse",     32'(out_valid), 32'd0);
      check("add_hold",      32'(out),       32'd9);

      // ADD overflow into bit WIDTH: 7+7+1 = 15
      issue(3'b010, 3'd7, 3'd7);
      tick();
      check("add_carry",     32'(out),       32'd15);
      cin = 0;

      // MUL 7*6 = 42, a competing request during MUL must be ignored
      issue(3'b011, 3'd7, 3'd6);
      opcode = 3'b010; A = 3'd1; B = 3'd1; in_valid = 1;
      check("mul_busy0",     32'(in_ready),  32'd0);
      tick();
      check("mul_busy1",     32'(in_ready),  32'd0);
      check("mul_nv1",       32'(out_valid), 32'd0);
      tick();
      check("mul_busy2",     32'(in_ready),  32'd0);
      check("mul_out_held",  32'(out),       32'd15);
      in_valid = 0;
      tick();
      check("mul_out",       32'(out),       32'd42);
      check("mul_valid",     32'(out_valid), 32'd1);
      check("mul_ready",     32'(in_ready),  32'd1);
      tick();
      check("mul_no_extra",  32'(out_valid), 32'd0);
      check("mul_hold",      32'(out),       32'd42);

      // invalid opcode: sticky err and blinking LEDs
      issue(3'b110, 3'd1, 3'd0);
      tick();
      check("inv_out",       32'(out),       32'd0);
      check("inv_err",       32'(err),       32'd1);
      check("inv_valid",     32'(out_valid), 32'd1);
      check("inv_leds0",     32'(leds),      32'hFFFF);
      tick();
      check("inv_leds1",     32'(leds),      32'h0000);
      check("inv_err_stk",   32'(err),       32'd1);
      tick();
      check("inv_leds2",     32'(leds),      32'hFFFF);

      // valid AND 6&3 = 2 clears err
      issue(3'b000, 3'd6, 3'd3);
      tick();
      check("and_out",       32'(out),       32'd2);
      check("and_err_clr",   32'(err),       32'd0);
      check("and_leds_clr",  32'(leds),      32'd0);

      // reduction on an arithmetic opcode is invalid
      red_op_A = 1;
      issue(3'b010, 3'd3, 3'd3);
      tick();
      check("redadd_err",    32'(err),       32'd1);
      check("redadd_out",    32'(out),       32'd0);

      // XOR reduction of A=7 -> 1, also clears err
      issue(3'b001, 3'd7, 3'd0);
      tick();
      check("xor_red_out",   32'(out),       32'd1);
      check("xor_red_err",   32'(err),       32'd0);
      red_op_A = 0;

      // both bypass with invalid opcode: priority operand A
      bypass_A = 1; bypass_B = 1;
      issue(3'b111, 3'd2, 3'd5);
      tick();
      check("byp_out",       32'(out),       32'd2);
      check("byp_err",       32'(err),       32'd0);
      check("byp_valid",     32'(out_valid), 32'd1);
      bypass_B = 0;

      // load out=000001 through bypass_A, then shift and rotate
      issue(3'b000, 3'd1, 3'd0);
      tick();
      check("load_out",      32'(out),       32'd1);
      bypass_A = 0;
      direction = 1; serial_in = 1;
      issue(3'b100, 3'd0, 3'd0);
      tick();
      check("shl_out",       32'(out),       32'h03);
      direction = 0; serial_in = 0;
      issue(3'b101, 3'd0, 3'd0);
      tick();
      check("rotr_out",      32'(out),       32'h21);

      // reset two cycles after a MUL accept aborts it
      issue(3'b011, 3'd7, 3'd6);
      tick();
      rst = 1;
      #1;
      check("abort_out",     32'(out),       32'd0);
      check("abort_ready",   32'(in_ready),  32'd1);
      check("abort_err",     32'(err),       32'd0);
      tick();
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort_no_vld", 32'(out_valid), 32'd0);
      end
      check("abort_out_end", 32'(out),       32'd0);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
